gp_trigger_sequencer: RTL

Control FSM of the GP engine that sits directly downstream of the trigger-configuration register file. It fetches the four trigger-source configurations over the register file's read handshake and watches four trigger inputs. For each armed trigger it issues one bus transaction on the engine's master interface. Results are reported through status outputs.

---
 rtl/gp_engine_pkg.sv | 40 ++++
 rtl/gp_trig_edge_detect.sv | 39 +++
 rtl/gp_trigger_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/gp_engine_pkg.sv
// Shared types and constants for the GP engine trigger path: FSM states, config
// word field layout and the lowest-pending-source priority pick.
package gp_engine_pkg;

  localparam int unsigned NumSrc = 4;

  localparam int unsigned CfgEnBit   = 31;
  localparam int unsigned CfgRdWrBit = 30;
  localparam int unsigned CfgByteMsb = 23;
  localparam int unsigned CfgByteLsb = 16;
  localparam int unsigned CfgOffMsb  = 15;
  localparam int unsigned CfgOffLsb  = 0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StFetchWait,
    StBackoff,
    StArmed,
    StIssue,
    StRdWait
  } gp_state_e;

  typedef struct packed {
    logic        en;
    logic        rd0_wr1;
    logic [5:0]  rsvd;
    logic [7:0]  wr_byte;
    logic [15:0] offset;
  } trig_cfg_t;

  // Lowest set index wins; returns 0 for an empty mask.
  function automatic logic [1:0] lowest_src(input logic [NumSrc-1:0] pend);
    lowest_src = 2'd0;
    for (int i = NumSrc - 1; i >= 0; i--) begin
      if (pend[i]) lowest_src = 2'(i);
    end
  endfunction

endpackage

// File: rtl/gp_trig_edge_detect.sv
// Registered rising-edge detect on the trigger inputs feeding a per-source pending
// vector; a new edge beats a same-cycle service clear, flush beats everything.
module gp_trig_edge_detect
  import gp_engine_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [NumSrc-1:0] trig_i,
  input  logic [NumSrc-1:0] arm_i,
  input  logic [NumSrc-1:0] clr_i,
  input  logic              flush_i,
  output logic [NumSrc-1:0] pend_o
);

  logic [NumSrc-1:0] trig_q;
  logic [NumSrc-1:0] pend_q;
  logic [NumSrc-1:0] pend_d;
  logic [NumSrc-1:0] rise;

  assign rise = trig_i & ~trig_q & arm_i;

  always_comb begin
    pend_d = (pend_q & ~clr_i) | rise;
    if (flush_i) pend_d = '0;
  end

  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      trig_q <= '0;
      pend_q <= '0;
    end else begin
      trig_q <= trig_i;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/gp_trigger_sequencer.sv
// GP engine control FSM: fetches the four trigger configs from the register file,
// then issues one master transaction per armed trigger edge, lowest source first.
module gp_trigger_sequencer
  import gp_engine_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           TIMEOUT    = 255,
  parameter int unsigned           RETRY_GAP  = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_en,
  input  logic                  i_cfg_update,
  input  logic [NumSrc-1:0]     i_trig,
  output logic                  reg_rd_en,
  input  logic                  reg_rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_trig_s1_config,
  input  logic [DATA_WIDTH-1:0] rd_trig_s2_config,
  input  logic [DATA_WIDTH-1:0] rd_trig_s3_config,
  input  logic [DATA_WIDTH-1:0] rd_trig_s4_config,
  output logic                  mst_o_valid,
  output logic [ADDR_WIDTH-1:0] mst_o_addr,
  output logic [DATA_WIDTH-1:0] mst_o_wr_data,
  output logic                  mst_o_rd0_wr1,
  input  logic                  mst_i_ready,
  input  logic                  mst_i_rd_valid,
  input  logic [DATA_WIDTH-1:0] mst_i_rd_data,
  output logic [DATA_WIDTH-1:0] o_last_rd_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
  localparam logic [7:0] RetryLast   = 8'(RETRY_GAP - 1);

  gp_state_e             state_q;
  trig_cfg_t             cfg_q [NumSrc];
  logic [7:0]            cnt_q;
  logic [1:0]            sel_q;
  logic                  upd_pend_q;
  logic                  busy_q;
  logic                  rd_en_q;
  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rdwr_q;
  logic [DATA_WIDTH-1:0] last_rd_q;
  logic                  done_q;
  logic                  err_q;

  logic [31:0]       cfg_words [NumSrc];
  logic [NumSrc-1:0] pend;
  logic [NumSrc-1:0] arm;
  logic [NumSrc-1:0] clr_vec;
  logic [NumSrc-1:0] sel_onehot;
  logic [1:0]        next_sel;
  trig_cfg_t         next_cfg;
  logic              issue_to;
  logic              rd_to;
  logic              unused_rsvd;

  assign cfg_words[0] = rd_trig_s1_config[31:0];
  assign cfg_words[1] = rd_trig_s2_config[31:0];
  assign cfg_words[2] = rd_trig_s3_config[31:0];
  assign cfg_words[3] = rd_trig_s4_config[31:0];

  for (genvar g = 0; g < NumSrc; g++) begin : g_arm
    assign arm[g] = cfg_q[g].en;
  end

  assign unused_rsvd = ^{cfg_q[0].rsvd, cfg_q[1].rsvd, cfg_q[2].rsvd, cfg_q[3].rsvd};

  assign next_sel   = lowest_src(pend);
  assign next_cfg   = cfg_q[next_sel];
  assign sel_onehot = NumSrc'(1) << sel_q;

  assign issue_to = (state_q == StIssue) && !mst_i_ready && (cnt_q == TimeoutLast);
  assign rd_to    = (state_q == StRdWait) && !mst_i_rd_valid && (cnt_q == TimeoutLast);

  // Service clear for the source in flight: on the accepting handshake or on a timeout.
  always_comb begin
    clr_vec = '0;
    if (((state_q == StIssue) && mst_i_ready) || issue_to || rd_to) clr_vec = sel_onehot;
  end

  gp_trig_edge_detect u_edge (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .trig_i  (i_trig),
    .arm_i   (arm),
    .clr_i   (clr_vec),
    .flush_i (~i_en),
    .pend_o  (pend)
  );

  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sel_q      <= '0;
      upd_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdwr_q     <= 1'b0;
      last_rd_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < NumSrc; i++) cfg_q[i] <= '0;
    end else if (!i_en) begin
      // Abort: outputs back to reset values, fetched configs are kept.
      state_q    <= StIdle;
      cnt_q      <= '0;
      sel_q      <= '0;
      upd_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdwr_q     <= 1'b0;
      last_rd_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          state_q    <= StFetch;
          rd_en_q    <= 1'b1;
          busy_q     <= 1'b1;
          upd_pend_q <= 1'b0;
        end
        StFetch: begin
          rd_en_q <= 1'b0;
          state_q <= StFetchWait;
        end
        StFetchWait: begin
          if (reg_rd_valid) begin
            for (int i = 0; i < NumSrc; i++) cfg_q[i] <= trig_cfg_t'(cfg_words[i]);
            state_q <= StArmed;
          end else begin
            cnt_q   <= '0;
            state_q <= StBackoff;
          end
        end
        StBackoff: begin
          if (cnt_q == RetryLast) begin
            state_q    <= StFetch;
            rd_en_q    <= 1'b1;
            upd_pend_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StArmed: begin
          if (upd_pend_q) begin
            state_q    <= StFetch;
            rd_en_q    <= 1'b1;
            upd_pend_q <= 1'b0;
          end else if (|pend) begin
            sel_q   <= next_sel;
            addr_q  <= BASE_ADDR + ADDR_WIDTH'(next_cfg.offset);
            wdata_q <= DATA_WIDTH'(next_cfg.wr_byte);
            rdwr_q  <= next_cfg.rd0_wr1;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (mst_i_ready) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            if (rdwr_q) begin
              done_q  <= 1'b1;
              state_q <= StArmed;
            end else begin
              state_q <= StRdWait;
            end
          end else if (cnt_q == TimeoutLast) begin
            err_q   <= 1'b1;
            valid_q <= 1'b0;
            state_q <= StArmed;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StRdWait: begin
          if (mst_i_rd_valid) begin
            last_rd_q <= mst_i_rd_data;
            done_q    <= 1'b1;
            state_q   <= StArmed;
          end else if (cnt_q == TimeoutLast) begin
            err_q   <= 1'b1;
            state_q <= StArmed;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
      // A request arriving while a fetch is being entered is kept for the next idle point.
      if (i_cfg_update) upd_pend_q <= 1'b1;
    end
  end

  assign reg_rd_en      = rd_en_q;
  assign mst_o_valid    = valid_q;
  assign mst_o_addr     = addr_q;
  assign mst_o_wr_data  = wdata_q;
  assign mst_o_rd0_wr1  = rdwr_q;
  assign o_last_rd_data = last_rd_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_err          = err_q;

endmodule
